// File: rtl/icache_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// icache_axi_rd_bridge
//
// Serves instruction-cache refills on the AXI read channels. One request is
// taken at a time. It becomes a single AR burst: 8 beats for a line and 1 beat
// for an uncached word. The 32-bit R beats are collected into a 256-bit line
// buffer. The line goes back to the icache with a one-cycle ret_valid pulse.
//
// Optional build macro: ICACHE_BRIDGE_RCHK_EN
//   When defined, R beats whose rid differs from AXI_ID are drained without
//   being stored or counted. A ret_err output reports SLVERR/DECERR (rresp[1])
//   seen on any accepted beat of the burst. When undefined, rid and rresp are
//   ignored and ret_err does not exist.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   rd_req, rd_type   refill request; rd_type=1 line, 0 uncached word
//   rd_addr           request address
//   rd_rdy            request can be accepted this cycle
//   ret_valid         one-cycle pulse, ret_data valid
//   ret_data          assembled line, word0 in [31:0]
//   ar*               AXI read address channel (arid/araddr/arlen/arsize/arburst/arvalid/arready)
//   r*                AXI read data channel (rid/rdata/rresp/rlast/rvalid/rready)
//   ret_err           (RCHK build only) error flag qualified by ret_valid
// -----------------------------------------------------------------------------
module icache_axi_rd_bridge #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_req,
  input  logic                       rd_type,
  input  logic [31:0]                rd_addr,
  output logic                       rd_rdy,
  output logic                       ret_valid,
  output logic [LINE_WORDS*32-1:0]   ret_data,
  output logic [3:0]                 arid,
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [3:0]                 rid,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
`ifdef ICACHE_BRIDGE_RCHK_EN
  ,
  output logic                       ret_err
`endif
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_AR   = 4'b0010,
    S_R    = 4'b0100,
    S_RET  = 4'b1000
  } state_t;

  state_t                          state;
  logic [LINE_WORDS-1:0][31:0]     line_buf;
  logic [2:0]                      cnt;
  logic                            beat_ok;
  logic                            unused_r;

  assign arid     = AXI_ID;
  assign arsize   = 3'b010;
  assign arburst  = 2'b01;

  // The line buffer is the return register itself. It keeps the last line
  // until the next accepted request clears it.
  assign ret_data = line_buf;

  // A beat is taken into the line only if it belongs to this bridge's ID.
  // Without the check, every handshaken beat counts.
`ifdef ICACHE_BRIDGE_RCHK_EN
  assign beat_ok = rvalid && rready && (rid == AXI_ID);
`else
  assign beat_ok = rvalid && rready;
`endif

  // R-channel fields that only the optional check looks at.
  assign unused_r = ^{rid, rresp};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rd_rdy    <= 1'b1;
      ret_valid <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      araddr    <= 32'd0;
      arlen     <= 8'd0;
      line_buf  <= '0;
      cnt       <= 3'd0;
`ifdef ICACHE_BRIDGE_RCHK_EN
      ret_err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_req) begin
            araddr   <= rd_addr;
            arlen    <= rd_type ? 8'(LINE_WORDS - 1) : 8'd0;
            line_buf <= '0;
            cnt      <= 3'd0;
`ifdef ICACHE_BRIDGE_RCHK_EN
            ret_err  <= 1'b0;
`endif
            rd_rdy   <= 1'b0;
            arvalid  <= 1'b1;
            state    <= S_AR;
          end
        end

        // arvalid stays high with a stable address until the handshake.
        S_AR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end

        // The beat counter stops at the top word. Extra beats from a
        // misbehaving slave overwrite word 7 and do not wrap onto word 0.
        S_R: begin
          if (beat_ok) begin
            line_buf[cnt] <= rdata;
            if (cnt != 3'd7) begin
              cnt <= cnt + 3'd1;
            end
`ifdef ICACHE_BRIDGE_RCHK_EN
            ret_err <= ret_err | rresp[1];
`endif
            if (rlast) begin
              rready    <= 1'b0;
              ret_valid <= 1'b1;
              state     <= S_RET;
            end
          end
        end

        S_RET: begin
          ret_valid <= 1'b0;
          rd_rdy    <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          ret_valid <= 1'b0;
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          rd_rdy    <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
module tb_icache_axi_rd_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req;
  logic         rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [255:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
`ifdef ICACHE_BRIDGE_RCHK_EN
  logic         ret_err;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  icache_axi_rd_bridge #(.AXI_ID(4'd0), .LINE_WORDS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_data  (ret_data),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready)
`ifdef ICACHE_BRIDGE_RCHK_EN
    ,
    .ret_err   (ret_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic typ);
    rd_addr = addr;
    rd_type = typ;
    rd_req  = 1'b1;
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic ar_hs;
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic [3:0] id, input logic [1:0] resp);
    rvalid = 1'b1;
    rdata  = d;
    rlast  = l;
    rid    = id;
    rresp  = resp;
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rid    = 4'd0;
    rresp  = 2'b00;
  endtask

  task automatic test_reset;
    tick();
    total_cnt++; if (rd_rdy !== 1'b1) $display("FAIL rst_rd_rdy: got %b exp 1", rd_rdy); else pass_cnt++;
    total_cnt++; if (ret_valid !== 1'b0) $display("FAIL rst_ret_valid: got %b exp 0", ret_valid); else pass_cnt++;
    total_cnt++; if (ret_data !== 256'd0) $display("FAIL rst_ret_data: got %h exp 0", ret_data); else pass_cnt++;
    total_cnt++; if ({arvalid, rready} !== 2'b00) $display("FAIL rst_valids: got %b exp 00", {arvalid, rready}); else pass_cnt++;
    total_cnt++; if (araddr !== 32'd0 || arlen !== 8'd0) $display("FAIL rst_ar: got %h/%h exp 0/0", araddr, arlen); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_line_read;
    logic [255:0] exp;
    for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'h11 * (i + 1);
    issue(32'h1FC0_0020, 1'b1);
    total_cnt++; if (arvalid !== 1'b1 || rd_rdy !== 1'b0) $display("FAIL line_accept: got arvalid=%b rd_rdy=%b exp 1/0", arvalid, rd_rdy); else pass_cnt++;
    total_cnt++; if (araddr !== 32'h1FC0_0020) $display("FAIL line_araddr: got %h exp 1fc00020", araddr); else pass_cnt++;
    total_cnt++; if (arlen !== 8'd7) $display("FAIL line_arlen: got %0d exp 7", arlen); else pass_cnt++;
    total_cnt++; if (arsize !== 3'd2 || arburst !== 2'd1 || arid !== 4'd0) $display("FAIL line_arconst: got %0d/%0d/%0d exp 2/1/0", arsize, arburst, arid); else pass_cnt++;
    ar_hs();
    total_cnt++; if (arvalid !== 1'b0 || rready !== 1'b1) $display("FAIL line_r_enter: got arvalid=%b rready=%b exp 0/1", arvalid, rready); else pass_cnt++;
    for (int i = 0; i < 7; i++) beat(32'h11 * (i + 1), 1'b0, 4'd0, 2'b00);
    total_cnt++; if (ret_valid !== 1'b0) $display("FAIL line_early_ret: got %b exp 0", ret_valid); else pass_cnt++;
    beat(32'h88, 1'b1, 4'd0, 2'b00);
    total_cnt++; if (ret_valid !== 1'b1 || rready !== 1'b0) $display("FAIL line_ret: got ret_valid=%b rready=%b exp 1/0", ret_valid, rready); else pass_cnt++;
    total_cnt++; if (ret_data[31:0] !== 32'h11 || ret_data[255:224] !== 32'h88) $display("FAIL line_words: got %h/%h exp 11/88", ret_data[31:0], ret_data[255:224]); else pass_cnt++;
    total_cnt++; if (ret_data !== exp) $display("FAIL line_data: got %h exp %h", ret_data, exp); else pass_cnt++;
    tick();
    total_cnt++; if (ret_valid !== 1'b0 || rd_rdy !== 1'b1) $display("FAIL line_idle: got ret_valid=%b rd_rdy=%b exp 0/1", ret_valid, rd_rdy); else pass_cnt++;
    total_cnt++; if (ret_data !== exp) $display("FAIL line_hold: got %h exp %h", ret_data, exp); else pass_cnt++;
  endtask

  task automatic test_uncached;
    issue(32'hBFAF_F004, 1'b0);
    total_cnt++; if (arlen !== 8'd0 || araddr !== 32'hBFAF_F004) $display("FAIL unc_ar: got arlen=%0d araddr=%h exp 0/bfaff004", arlen, araddr); else pass_cnt++;
    total_cnt++; if (rd_rdy !== 1'b0) $display("FAIL unc_rdy_ar: got %b exp 0", rd_rdy); else pass_cnt++;
    ar_hs();
    total_cnt++; if (rd_rdy !== 1'b0) $display("FAIL unc_rdy_r: got %b exp 0", rd_rdy); else pass_cnt++;
    beat(32'hDEADBEEF, 1'b1, 4'd0, 2'b00);
    total_cnt++; if (ret_valid !== 1'b1 || rd_rdy !== 1'b0) $display("FAIL unc_ret: got ret_valid=%b rd_rdy=%b exp 1/0", ret_valid, rd_rdy); else pass_cnt++;
    total_cnt++; if (ret_data !== {224'd0, 32'hDEADBEEF}) $display("FAIL unc_data: got %h exp deadbeef", ret_data); else pass_cnt++;
    tick();
    total_cnt++; if (rd_rdy !== 1'b1 || ret_valid !== 1'b0) $display("FAIL unc_rdy_back: got rd_rdy=%b ret_valid=%b exp 1/0", rd_rdy, ret_valid); else pass_cnt++;
  endtask

  task automatic test_stalls;
    logic [255:0] exp;
    int pulses;
    int bad_ar;
    pulses = 0;
    bad_ar = 0;
    for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'hA000_0000 + i;
    issue(32'h0000_1040, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (arvalid !== 1'b1 || araddr !== 32'h0000_1040 || arlen !== 8'd7) bad_ar++;
    end
    total_cnt++; if (bad_ar !== 0) $display("FAIL stall_ar_stable: got %0d unstable cycles exp 0", bad_ar); else pass_cnt++;
    ar_hs();
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 3; g++) begin
        tick();
        if (ret_valid) pulses++;
      end
      beat(32'hA000_0000 + i, (i == 7), 4'd0, 2'b00);
      if (ret_valid) pulses++;
    end
    total_cnt++; if (ret_valid !== 1'b1) $display("FAIL stall_ret: got %b exp 1", ret_valid); else pass_cnt++;
    total_cnt++; if (ret_data !== exp) $display("FAIL stall_data: got %h exp %h", ret_data, exp); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ret_valid) pulses++;
    end
    total_cnt++; if (pulses !== 1) $display("FAIL stall_pulses: got %0d exp 1", pulses); else pass_cnt++;
  endtask

  task automatic test_early_rlast;
    issue(32'h0000_2000, 1'b1);
    ar_hs();
    beat(32'hAAAA_0001, 1'b0, 4'd0, 2'b00);
    beat(32'hBBBB_0002, 1'b0, 4'd0, 2'b00);
    beat(32'hCCCC_0003, 1'b1, 4'd0, 2'b00);
    total_cnt++; if (ret_valid !== 1'b1) $display("FAIL early_ret: got %b exp 1", ret_valid); else pass_cnt++;
    total_cnt++; if (ret_data !== {160'd0, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}) $display("FAIL early_data: got %h", ret_data); else pass_cnt++;
    tick();
    total_cnt++; if (rd_rdy !== 1'b1 || rready !== 1'b0) $display("FAIL early_idle: got rd_rdy=%b rready=%b exp 1/0", rd_rdy, rready); else pass_cnt++;
  endtask

  task automatic test_overrun;
    logic [255:0] exp;
    for (int i = 0; i < 7; i++) exp[i*32 +: 32] = 32'h200 + i;
    exp[255:224] = 32'h209;
    issue(32'h0000_3000, 1'b1);
    ar_hs();
    for (int i = 0; i < 10; i++) beat(32'h200 + i, (i == 9), 4'd0, 2'b00);
    total_cnt++; if (ret_valid !== 1'b1 || ret_data !== exp) $display("FAIL overrun_data: got v=%b %h exp %h", ret_valid, ret_data, exp); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_burst;
    logic [255:0] exp;
    for (int i = 0; i < 8; i++) exp[i*32 +: 32] = 32'h3000 + i;
    issue(32'h0000_4000, 1'b1);
    ar_hs();
    for (int i = 0; i < 4; i++) beat(32'h5000 + i, 1'b0, 4'd0, 2'b00);
    total_cnt++; if (rready !== 1'b1) $display("FAIL mid_rready: got %b exp 1", rready); else pass_cnt++;
    #3;
    reset = 1'b1;
    #1;
    total_cnt++; if ({arvalid, rready, ret_valid} !== 3'b000) $display("FAIL mid_rst_outs: got %b exp 000", {arvalid, rready, ret_valid}); else pass_cnt++;
    total_cnt++; if (rd_rdy !== 1'b1 || ret_data !== 256'd0) $display("FAIL mid_rst_rdy: got rd_rdy=%b data=%h exp 1/0", rd_rdy, ret_data); else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    issue(32'h0000_5020, 1'b1);
    total_cnt++; if (araddr !== 32'h0000_5020 || arvalid !== 1'b1) $display("FAIL post_rst_ar: got %h/%b exp 00005020/1", araddr, arvalid); else pass_cnt++;
    ar_hs();
    for (int i = 0; i < 8; i++) beat(32'h3000 + i, (i == 7), 4'd0, 2'b00);
    total_cnt++; if (ret_valid !== 1'b1 || ret_data !== exp) $display("FAIL post_rst_data: got v=%b %h exp %h", ret_valid, ret_data, exp); else pass_cnt++;
    tick();
  endtask

  task automatic test_rid_rresp;
    logic [255:0] exp;
`ifdef ICACHE_BRIDGE_RCHK_EN
    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'h400 + k;
    issue(32'h0000_6000, 1'b1);
    ar_hs();
    for (int j = 0, k = 0; j < 9; j++) begin
      if (j == 2) begin
        beat(32'hBAD0_BAD0, 1'b0, 4'd1, 2'b00);
      end else begin
        beat(32'h400 + k, (j == 8), 4'd0, (j == 5) ? 2'b10 : 2'b00);
        k++;
      end
      if (j == 2) begin
        total_cnt++; if (rready !== 1'b1) $display("FAIL rchk_rready: got %b exp 1", rready); else pass_cnt++;
      end
    end
    total_cnt++; if (ret_valid !== 1'b1 || ret_data !== exp) $display("FAIL rchk_data: got v=%b %h exp %h", ret_valid, ret_data, exp); else pass_cnt++;
    total_cnt++; if (ret_err !== 1'b1) $display("FAIL rchk_err: got %b exp 1", ret_err); else pass_cnt++;
    tick();
    issue(32'h0000_7004, 1'b0);
    total_cnt++; if (ret_err !== 1'b0) $display("FAIL rchk_err_clr: got %b exp 0", ret_err); else pass_cnt++;
    ar_hs();
    beat(32'h1234_5678, 1'b1, 4'd0, 2'b00);
    total_cnt++; if (ret_err !== 1'b0 || ret_data !== {224'd0, 32'h1234_5678}) $display("FAIL rchk_clean: got err=%b %h", ret_err, ret_data); else pass_cnt++;
    tick();
`else
    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'h400 + k;
    issue(32'h0000_6000, 1'b1);
    ar_hs();
    for (int k = 0; k < 8; k++)
      beat(32'h400 + k, (k == 7), (k == 2) ? 4'd1 : 4'd0, (k == 5) ? 2'b10 : 2'b00);
    total_cnt++; if (ret_valid !== 1'b1 || ret_data !== exp) $display("FAIL norchk_data: got v=%b %h exp %h", ret_valid, ret_data, exp); else pass_cnt++;
    tick();
`endif
  endtask

  initial begin
    reset   = 1'b1;
    rd_req  = 1'b0;
    rd_type = 1'b0;
    rd_addr = 32'd0;
    arready = 1'b0;
    rid     = 4'd0;
    rdata   = 32'd0;
    rresp   = 2'b00;
    rlast   = 1'b0;
    rvalid  = 1'b0;
    test_reset();
    test_line_read();
    test_uncached();
    test_stalls();
    test_early_rlast();
    test_overrun();
    test_reset_mid_burst();
    test_rid_rresp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
